// File: rtl/vec_result_drain_if.sv
// Byte stream carrying drained output-vector elements toward the host side.
// The drain drives data/valid/last; the consumer drives ready.
interface vec_result_drain_if #(
  parameter int ElemWidth = 8
);
  logic [ElemWidth-1:0] m_data_out;
  logic                 m_valid_out;
  logic                 m_ready_in;
  logic                 m_last_out;

  modport master (
    output m_data_out,
    output m_valid_out,
    output m_last_out,
    input  m_ready_in
  );

  modport slave (
    input  m_data_out,
    input  m_valid_out,
    input  m_last_out,
    output m_ready_in
  );
endinterface

// File: rtl/vec_result_drain.sv
// Drains the last-layer output VecFIFO one element per request into a credit-managed
// elastic buffer feeding a valid/ready stream. Optional macro DRAIN_HEADER_EN prepends a count header.
module vec_result_drain #(
  parameter int VecElements = 8,
  parameter int ElemWidth   = 8,
  parameter int BufDepth    = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 vec_valid_in,
  output logic                 vec_ack_out,
  output logic                 req_chunk_out,
  input  logic [ElemWidth-1:0] in_data,
  vec_result_drain_if.master   m_if,
  output logic                 busy_out,
  output logic [15:0]          vec_count_out
);

  localparam int PtrW = $clog2(BufDepth);
  localparam int CntW = PtrW + 1;
  localparam int IssW = $clog2(VecElements + 1);
  localparam int LastIdx = VecElements - 1;

  localparam logic [CntW:0]   DEPTH_C    = BufDepth[CntW:0];
  localparam logic [IssW-1:0] VEC_C      = VecElements[IssW-1:0];
  localparam logic [IssW-1:0] LAST_IDX_C = LastIdx[IssW-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IssW-1:0]      issued_q, issued_d;
  logic                 infl_q, infl_last_q;
  logic [15:0]          vec_count_q, vec_count_d;

  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [ElemWidth-1:0] mem_q [BufDepth];
  logic                 last_mem_q [BufDepth];

  logic                 push, pop, credit_ok, req_last, wr_last, buf_valid;
  logic [ElemWidth-1:0] wr_data;
  logic [CntW:0]        used;

`ifdef DRAIN_HEADER_EN
  logic hdr_pend_q, hdr_pend_d, hdr_push;
`endif

  // Credit: entries held plus the one read still in flight from the VecFIFO.
  assign used      = {1'b0, count_q} + {{CntW{1'b0}}, infl_q};
  assign credit_ok = used < DEPTH_C;
  assign req_last  = issued_q == LAST_IDX_C;
  assign buf_valid = count_q != '0;
  assign pop       = buf_valid & m_if.m_ready_in;

`ifdef DRAIN_HEADER_EN
  // The header is written in the first FETCH cycle, when no VecFIFO read can be in flight.
  assign push    = infl_q | hdr_push;
  assign wr_data = hdr_push ? ElemWidth'(vec_count_q) : in_data;
  assign wr_last = hdr_push ? 1'b0 : infl_last_q;
`else
  assign push    = infl_q;
  assign wr_data = in_data;
  assign wr_last = infl_last_q;
`endif

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    req_chunk_out = 1'b0;
    vec_ack_out   = 1'b0;
`ifdef DRAIN_HEADER_EN
    hdr_pend_d    = hdr_pend_q;
    hdr_push      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (vec_valid_in) begin
          state_d  = S_FETCH;
          issued_d = '0;
`ifdef DRAIN_HEADER_EN
          hdr_pend_d = 1'b1;
`endif
        end
      end
      S_FETCH: begin
`ifdef DRAIN_HEADER_EN
        if (hdr_pend_q) begin
          hdr_push   = 1'b1;
          hdr_pend_d = 1'b0;
        end else
`endif
        if (issued_q < VEC_C && credit_ok) begin
          req_chunk_out = 1'b1;
          issued_d      = issued_q + 1'b1;
        end
        if (issued_q == VEC_C && !infl_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!buf_valid) state_d = S_DONE;
      end
      S_DONE: begin
        vec_ack_out = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vec_count_d = vec_count_q + {15'd0, vec_ack_out};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      vec_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef DRAIN_HEADER_EN
      hdr_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      infl_q      <= req_chunk_out;
      infl_last_q <= req_chunk_out & req_last;
      vec_count_q <= vec_count_d;
`ifdef DRAIN_HEADER_EN
      hdr_pend_q  <= hdr_pend_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is not reset; clearing the pointers and count empties the buffer,
  // and outputs are gated by valid so stale contents are never visible.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= wr_data;
      last_mem_q[wr_ptr_q] <= wr_last;
    end
  end

  assign m_if.m_valid_out = buf_valid;
  assign m_if.m_data_out  = buf_valid ? mem_q[rd_ptr_q] : '0;
  assign m_if.m_last_out  = buf_valid & last_mem_q[rd_ptr_q];
  assign busy_out         = state_q != S_IDLE;
  assign vec_count_out    = vec_count_q;

endmodule
